// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier response checker: default widths,
// FSM state encodings and the all-ones constant that counters saturate at.
package mult_pkg;

  localparam int unsigned W_DEF     = 4;
  localparam int unsigned CNT_W_DEF = 16;

  // Truncated to CNT_W bits by the user to get the counter saturation value.
  localparam logic [31:0] CNT_SAT_ALL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CMP  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_check_monitor_if.sv
// Valid/ready vector bus observed at the multiplier boundary (A, B, product).
interface mult_check_monitor_if #(
  parameter int unsigned W = mult_pkg::W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [2*W-1:0]   in_p;

  modport master (output in_valid, output in_a, output in_b, output in_p, input  in_ready);
  modport slave  (input  in_valid, input  in_a, input  in_b, input  in_p, output in_ready);

endinterface

// File: rtl/mult_shift_add_core.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, W cycles.
// done_o is high during the cycle in which the final bit is folded into acc_o.
module mult_shift_add_core
  import mult_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [2*W-1:0]   acc_o,
  output logic             done_o
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned IDX_W = (W > 2) ? $clog2(W) : 1;

  logic [PW-1:0]    a_q,    a_d;
  logic [PW-1:0]    acc_q,  acc_d;
  logic [W-1:0]     b_q,    b_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state: load on start, otherwise consume one multiplier bit per cycle.
  always_comb begin
    a_d    = a_q;
    acc_d  = acc_q;
    b_d    = b_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      a_d    = PW'(a_i);
      b_d    = b_i;
      acc_d  = '0;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) begin
        acc_d = acc_q + (a_q << idx_q);
      end
      b_d    = b_q >> 1;
      idx_d  = idx_q + IDX_W'(1);
      // Flag the final step one cycle ahead so it is visible while it runs.
      done_d = (idx_q == IDX_W'(W - 2));
      busy_d = (idx_q != IDX_W'(W - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      acc_q  <= acc_d;
      b_q    <= b_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/mult_check_monitor.sv
// Response checker for the 4x4 multiplier: recomputes each product, compares,
// counts pass/fail and captures the first failing vector. Trace: MULT_CHK_TRACE_EN.
module mult_check_monitor
  import mult_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_check_monitor_if.slave  bus,
  input  logic                 cnt_clr,
  output logic                 chk_done,
  output logic                 chk_pass,
  output logic [2*W-1:0]       exp_p,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 ff_vld,
  output logic [W-1:0]         ff_a,
  output logic [W-1:0]         ff_b,
  output logic [2*W-1:0]       ff_p
);

  localparam int unsigned PW = 2 * W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT_ALL);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [PW-1:0]    p_q, p_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [PW-1:0]    exp_q, exp_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;
  logic             ffv_q, ffv_d;
  logic [W-1:0]     ffa_q, ffa_d, ffb_q, ffb_d;
  logic [PW-1:0]    ffp_q, ffp_d;

  logic             accept_c;
  logic             match_c;
  logic [PW-1:0]    core_acc;
  logic             core_done;

  assign accept_c = ready_q & bus.in_valid;
  assign match_c  = (core_acc == p_q);

  mult_shift_add_core #(.W(W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept_c),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .acc_o   (core_acc),
    .done_o  (core_done)
  );

  // Handshake FSM plus compare, counter and first-fail capture next-state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    exp_d   = exp_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    ffv_d   = ffv_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    ffp_d   = ffp_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          p_d     = bus.in_p;
          state_d = CALC;
        end
      end
      CALC: begin
        if (core_done) state_d = CMP;
      end
      CMP: begin
        done_d  = 1'b1;
        pass_d  = match_c;
        exp_d   = core_acc;
        state_d = IDLE;
        if (match_c) begin
          if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_W'(1);
        end else begin
          if (fcnt_q != CNT_MAX) fcnt_d = fcnt_q + CNT_W'(1);
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffa_d = a_q;
            ffb_d = b_q;
            ffp_d = p_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides any update from a coinciding compare.
    if (cnt_clr) begin
      pcnt_d = '0;
      fcnt_d = '0;
      ffv_d  = 1'b0;
      ffa_d  = '0;
      ffb_d  = '0;
      ffp_d  = '0;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      exp_q   <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
      ffv_q   <= 1'b0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      ffp_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      exp_q   <= exp_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
      ffv_q   <= ffv_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      ffp_q   <= ffp_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign chk_done     = done_q;
  assign chk_pass     = pass_q;
  assign exp_p        = exp_q;
  assign pass_cnt     = pcnt_q;
  assign fail_cnt     = fcnt_q;
  assign ff_vld       = ffv_q;
  assign ff_a         = ffa_q;
  assign ff_b         = ffb_q;
  assign ff_p         = ffp_q;

`ifdef MULT_CHK_TRACE_EN
  // Simulation-only trace of every compare.
  always @(posedge clk) begin
    if (!rst && state_q == CMP) begin
      $display("%0t mult_chk A=%0d B=%0d P=%0d EXP=%0d %s",
               $time, a_q, b_q, p_q, core_acc, match_c ? "PASS" : "FAIL");
      if (!match_c && !ffv_q && !cnt_clr)
        $display("%0t mult_chk FIRST FAIL A=%0d B=%0d P=%0d", $time, a_q, b_q, p_q);
    end
  end
`endif

endmodule

// File: tb/tb_mult_check_monitor.sv
// Scoreboard bench for mult_check_monitor: a second instance with 2-bit counters
// sees the same stream so saturation is exercised alongside the main checks.
module tb_mult_check_monitor;
  import mult_pkg::*;

  localparam int unsigned W     = 4;
  localparam int unsigned PW    = 8;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cnt_clr = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult_check_monitor_if #(.W(W)) bus  ();
  mult_check_monitor_if #(.W(W)) bus2 ();
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_a     = bus.in_a;
  assign bus2.in_b     = bus.in_b;
  assign bus2.in_p     = bus.in_p;

  logic             chk_done, chk_pass, ff_vld;
  logic [PW-1:0]    exp_p, ff_p;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [W-1:0]     ff_a, ff_b;

  logic             chk_done2, chk_pass2, ff_vld2;
  logic [PW-1:0]    exp_p2, ff_p2;
  logic [1:0]       pass_cnt2, fail_cnt2;
  logic [W-1:0]     ff_a2, ff_b2;

  mult_check_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .cnt_clr(cnt_clr),
    .chk_done(chk_done), .chk_pass(chk_pass), .exp_p(exp_p),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .ff_vld(ff_vld), .ff_a(ff_a), .ff_b(ff_b), .ff_p(ff_p)
  );

  mult_check_monitor #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .cnt_clr(cnt_clr),
    .chk_done(chk_done2), .chk_pass(chk_pass2), .exp_p(exp_p2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
    .ff_vld(ff_vld2), .ff_a(ff_a2), .ff_b(ff_b2), .ff_p(ff_p2)
  );

  typedef struct {
    int unsigned acc_cyc;
    logic        pass;
    logic [7:0]  expp;
    int unsigned pc, fc, pc2, fc2;
    logic        ffv;
    logic [3:0]  ffa, ffb;
    logic [7:0]  ffp;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model state: counts and first-fail record.
  int unsigned m_pc, m_fc, m_pc2, m_fc2;
  logic        m_ffv;
  logic [3:0]  m_ffa, m_ffb;
  logic [7:0]  m_ffp;
  bit          prev_held;
  int unsigned last_acc;

  task automatic model_reset();
    m_pc = 0; m_fc = 0; m_pc2 = 0; m_fc2 = 0;
    m_ffv = 1'b0; m_ffa = '0; m_ffb = '0; m_ffp = '0;
    prev_held = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                      input bit clr_cmp, input bit hold);
    int n;
    exp_t e;
    int unsigned prod;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_p = p; bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 32'(n), 32'(0));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (prev_held) chk("accept_spacing", 32'(cyc - last_acc), 32'(6));
    last_acc  = cyc;
    prev_held = hold;
    chk("ready_low_calc", 32'(bus.in_ready), 32'(0));
    prod = int'(a) * int'(b);
    e.acc_cyc = cyc;
    e.expp    = 8'(prod);
    e.pass    = (int'(p) == prod);
    if (clr_cmp) begin
      model_reset();
      prev_held = hold;
    end else if (e.pass) begin
      if (m_pc < 65535) m_pc++;
      if (m_pc2 < 3) m_pc2++;
    end else begin
      if (m_fc < 65535) m_fc++;
      if (m_fc2 < 3) m_fc2++;
      if (!m_ffv) begin
        m_ffv = 1'b1; m_ffa = a; m_ffb = b; m_ffp = p;
      end
    end
    e.pc = m_pc; e.fc = m_fc; e.pc2 = m_pc2; e.fc2 = m_fc2;
    e.ffv = m_ffv; e.ffa = m_ffa; e.ffb = m_ffb; e.ffp = m_ffp;
    sbq.push_back(e);
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.in_a = 4'($urandom); bus.in_b = 4'($urandom); bus.in_p = 8'($urandom);
    end
    if (clr_cmp) begin
      repeat (4) @(posedge clk);
      #1 cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
    end
  endtask

  // Monitor: pop and compare on every result pulse; otherwise check hold.
  logic       h_pass;
  logic [7:0] h_exp;
  exp_t       me;
  always @(negedge clk) begin
    if (rst) begin
      h_pass = 1'b0;
      h_exp  = '0;
    end else if (chk_done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'(1), 32'(0));
      end else begin
        me = sbq.pop_front();
        chk("latency",   32'(cyc - me.acc_cyc), 32'(5));
        chk("chk_pass",  32'(chk_pass), 32'(me.pass));
        chk("exp_p",     32'(exp_p),    32'(me.expp));
        chk("pass_cnt",  32'(pass_cnt), 32'(me.pc));
        chk("fail_cnt",  32'(fail_cnt), 32'(me.fc));
        chk("ff_vld",    32'(ff_vld),   32'(me.ffv));
        chk("ff_a",      32'(ff_a),     32'(me.ffa));
        chk("ff_b",      32'(ff_b),     32'(me.ffb));
        chk("ff_p",      32'(ff_p),     32'(me.ffp));
        chk("ready_at_done", 32'(bus.in_ready), 32'(1));
        chk("done2",     32'(chk_done2), 32'(1));
        chk("pass2",     32'(chk_pass2), 32'(me.pass));
        chk("exp_p2",    32'(exp_p2),    32'(me.expp));
        chk("pass_cnt2", 32'(pass_cnt2), 32'(me.pc2));
        chk("fail_cnt2", 32'(fail_cnt2), 32'(me.fc2));
        chk("ff_vld2",   32'(ff_vld2),   32'(me.ffv));
        chk("ff_a2",     32'(ff_a2),     32'(me.ffa));
        chk("ff_b2",     32'(ff_b2),     32'(me.ffb));
        chk("ff_p2",     32'(ff_p2),     32'(me.ffp));
        chk("ready2_at_done", 32'(bus2.in_ready), 32'(1));
        h_pass = me.pass;
        h_exp  = me.expp;
      end
    end else begin
      chk("hold_pass", 32'(chk_pass), 32'(h_pass));
      chk("hold_exp",  32'(exp_p),    32'(h_exp));
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_ready"},    32'(bus.in_ready), 32'(0));
    chk({tag, "_done"},     32'(chk_done),     32'(0));
    chk({tag, "_pass_cnt"}, 32'(pass_cnt),     32'(0));
    chk({tag, "_fail_cnt"}, 32'(fail_cnt),     32'(0));
    chk({tag, "_ff_vld"},   32'(ff_vld),       32'(0));
    chk({tag, "_exp_p"},    32'(exp_p),        32'(0));
  endtask

  task automatic do_reset(input string tag);
    #1 rst = 1'b1;
    sbq.delete();
    model_reset();
    @(negedge clk);
    check_cleared(tag);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    int n;
    logic [3:0] ra, rb;
    logic [7:0] rp;
    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_p = '0;
    model_reset();
    last_acc = 0;
    do_reset("reset");

    send(4'd3,  4'd5,  8'd15,  1'b0, 1'b0);
    send(4'd15, 4'd15, 8'd225, 1'b0, 1'b0);
    send(4'd15, 4'd15, 8'd224, 1'b0, 1'b0);
    send(4'd2,  4'd2,  8'd5,   1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(4'd0, 4'd9, 8'd0, 1'b0, 1'b0);

    // Valid held continuously; the next vector is presented mid-CALC.
    send(4'd7, 4'd6, 8'd42, 1'b0, 1'b1);
    send(4'd5, 4'd5, 8'd25, 1'b0, 1'b1);
    send(4'd9, 4'd3, 8'd26, 1'b0, 1'b1);
    send(4'd1, 4'd1, 8'd1,  1'b0, 1'b0);

    send(4'd4, 4'd4, 8'd15, 1'b1, 1'b0);

    // Reset during CALC drops the in-flight vector.
    send(4'd6, 4'd7, 8'd41, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    do_reset("rst_mid");
    send(4'd6, 4'd7, 8'd42, 1'b0, 1'b0);
    send(4'd8, 4'd3, 8'd25, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rp = 8'(int'(ra) * int'(rb));
      if ($urandom_range(0, 2) == 0) rp = rp ^ 8'($urandom_range(1, 255));
      send(ra, rb, rp, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
    end
    bus.in_valid = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
